// File: rtl/grf_dump_pkg.sv
// Shared types and constants for the GRF dump engine.
package grf_dump_pkg;

  localparam int         REG_CNT  = 32;
  localparam logic [4:0] LAST_IDX = 5'd31;
  localparam logic [5:0] CHK_IDX  = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_SUM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/grf_dump_if.sv
// Beat stream from the GRF dump engine: valid/ready plus index, payload, PC and last flag.
interface grf_dump_if #(
  parameter int DATA_W = 32
);

  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_idx;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       out_pc;
  logic              out_last;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    output out_pc,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    input  out_pc,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/grf_dump.sv
// Walks GRF indices 0..31 through one read port and streams each value as a tagged beat.
// Define GRF_DUMP_CHECKSUM_EN to append a 33rd beat carrying the XOR of all emitted words.
module grf_dump
  import grf_dump_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       pc,
  output logic              busy,
  output logic              done,
  output logic [4:0]        raddr,
  input  logic [DATA_W-1:0] rdata,
  grf_dump_if.master        out
);

  localparam logic [4:0] LAST_REG = 5'(REG_CNT - 1);

  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [5:0]        out_idx_q, out_idx_d;
  logic [31:0]       out_pc_q, out_pc_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_d;
`ifdef GRF_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_pc_d    = out_pc_q;
    out_last_d  = out_last_q;
    out_valid_d = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    raddr       = 5'd0;
`ifdef GRF_DUMP_CHECKSUM_EN
    acc_d       = acc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          out_pc_d = pc;
          idx_d    = 5'd0;
`ifdef GRF_DUMP_CHECKSUM_EN
          acc_d    = '0;
`endif
          state_d  = ST_READ;
        end
      end

      ST_READ: begin
        busy       = 1'b1;
        raddr      = idx_q;
        out_data_d = rdata;
        out_idx_d  = {1'b0, idx_q};
`ifdef GRF_DUMP_CHECKSUM_EN
        // The checksum beat is the last one, so no register beat carries out_last.
        out_last_d = 1'b0;
        acc_d      = acc_q ^ rdata;
`else
        out_last_d = (idx_q == LAST_REG);
`endif
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        busy        = 1'b1;
        out_valid_d = 1'b1;
        if (out.out_ready) begin
          // idx saturates at the last register; the FSM decides what follows it.
          if (idx_q == LAST_REG) begin
`ifdef GRF_DUMP_CHECKSUM_EN
            out_data_d = acc_q;
            out_idx_d  = CHK_IDX;
            out_last_d = 1'b1;
            state_d    = ST_SUM;
`else
            state_d    = ST_DONE;
`endif
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_READ;
          end
        end
      end

`ifdef GRF_DUMP_CHECKSUM_EN
      ST_SUM: begin
        busy        = 1'b1;
        out_valid_d = 1'b1;
        if (out.out_ready) begin
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 5'd0;
      out_data_q <= '0;
      out_idx_q  <= 6'd0;
      out_pc_q   <= 32'd0;
      out_last_q <= 1'b0;
`ifdef GRF_DUMP_CHECKSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_pc_q   <= out_pc_d;
      out_last_q <= out_last_d;
`ifdef GRF_DUMP_CHECKSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign out.out_valid = out_valid_d;
  assign out.out_data  = out_data_q;
  assign out.out_idx   = out_idx_q;
  assign out.out_pc    = out_pc_q;
  assign out.out_last  = out_last_q;

endmodule

// File: tb/tb_grf_dump.sv
// Bench for grf_dump: GRF model with write bypass, beat-level reference model, directed and random dumps.
`timescale 1ns/1ps
module tb_grf_dump;
  import grf_dump_pkg::*;

`ifdef GRF_DUMP_CHECKSUM_EN
  localparam int NB = 33;
`else
  localparam int NB = 32;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic        busy, done;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        we = 1'b0;
  logic [4:0]  waddr = 5'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] grf_mem [32] = '{default: 32'h0};

  grf_dump_if #(.DATA_W(32)) out_if ();

  grf_dump #(.DATA_W(32), .REG_CNT(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .pc    (pc_in),
    .busy  (busy),
    .done  (done),
    .raddr (raddr),
    .rdata (rdata),
    .out   (out_if)
  );

  // GRF: r0 hardwired to zero, write visible to a same-cycle read through the bypass.
  always @(posedge clk) if (we && waddr != 5'd0) grf_mem[waddr] <= wdata;
  assign rdata = (we && waddr != 5'd0 && waddr == raddr) ? wdata : grf_mem[raddr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state, owned by the compare process.
  bit          m_active = 0, m_done_due = 0, post_reset = 0, presented = 0;
  int          wait_cnt = 0, exp_idx = 0, cyc = 0, acc_cyc = 0;
  int          first_valid_rel = -1, done_rel = -1;
  int          beat_cnt = 0, last_cnt = 0, done_cnt = 0;
  logic [31:0] exp_pc = 0, exp_acc = 0, got_pc = 0;
  logic [31:0] got_data [NB];
  int          pres_cyc [NB];
  int          hs_cyc   [NB];

  always @(negedge clk) begin
    logic [31:0] exp_data;
    bit          exp_valid, exp_done;
    logic [4:0]  exp_raddr;
    cyc++;
    if (reset) begin
      m_active   = 0;
      m_done_due = 0;
      post_reset = 1;
    end else begin
      if (post_reset) begin
        chk("rst_ctrl", 64'({busy, done, raddr, out_if.out_valid, out_if.out_idx, out_if.out_last}), 64'd0);
        chk("rst_data", {out_if.out_data, out_if.out_pc}, 64'd0);
        post_reset = 0;
      end
      exp_valid = 0;
      exp_done  = 0;
      exp_raddr = 5'd0;
      if (m_done_due) begin
        exp_done   = 1;
        m_done_due = 0;
      end else if (m_active) begin
        if (wait_cnt > 0) wait_cnt--;
        exp_valid = (wait_cnt == 0);
        if (wait_cnt == 1) exp_raddr = 5'(exp_idx);
      end
      chk("valid", 64'(out_if.out_valid), 64'(exp_valid));
      chk("done",  64'(done), 64'(exp_done));
      chk("busy",  64'(busy), 64'(m_active));
      chk("raddr", 64'(raddr), 64'(exp_raddr));
      if (exp_valid) begin
        if (exp_idx < 32) exp_data = grf_mem[exp_idx];
        else              exp_data = exp_acc;
        if (!presented) begin
          presented = 1;
          pres_cyc[exp_idx] = cyc;
          if (exp_idx == 0) first_valid_rel = cyc - acc_cyc;
        end
        chk("beat_idx",  64'(out_if.out_idx), 64'(exp_idx));
        chk("beat_data", 64'(out_if.out_data), 64'(exp_data));
        chk("beat_pc",   64'(out_if.out_pc), 64'(exp_pc));
        chk("beat_last", 64'(out_if.out_last), 64'(exp_idx == NB - 1));
        if (out_if.out_ready) begin
          got_data[exp_idx] = out_if.out_data;
          hs_cyc[exp_idx]   = cyc;
          got_pc            = out_if.out_pc;
          beat_cnt++;
          if (out_if.out_last) last_cnt++;
          if (exp_idx < 32) exp_acc ^= exp_data;
          exp_idx++;
          presented = 0;
          if (exp_idx == NB) begin
            m_active   = 0;
            m_done_due = 1;
          end else begin
            wait_cnt = (exp_idx == 32) ? 1 : 2;
          end
        end
      end else if (!m_active && !exp_done && start) begin
        m_active  = 1;
        wait_cnt  = 2;
        exp_idx   = 0;
        exp_pc    = pc_in;
        exp_acc   = 32'd0;
        acc_cyc   = cyc;
        beat_cnt  = 0;
        last_cnt  = 0;
        presented = 0;
      end
      if (exp_done) begin
        done_cnt++;
        done_rel = cyc - acc_cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [31:0] p);
    start = 1'b1;
    pc_in = p;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_active || m_done_due) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(m_active || m_done_due), 64'd0);
  endtask

  task automatic wait_read(input logic [4:0] r, input string name);
    int n = 0;
    while (!(busy && raddr == r) && n < 200) begin
      tick();
      n++;
    end
    chk(name, 64'(n < 200), 64'd1);
  endtask

  initial begin
    int d0, n, j;
    out_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h11111111;
      tick();
    end
    we = 1'b0;

    // Basic dump with the consumer always ready.
    out_if.out_ready = 1'b1;
    start_dump(32'h0000_3000);
    wait_idle(300);
    chk("first_valid_lat", 64'(first_valid_rel), 64'd2);
    chk("done_lat",   64'(done_rel), 64'((NB == 33) ? 66 : 65));
    chk("beat_count", 64'(beat_cnt), 64'(NB));
    chk("last_count", 64'(last_cnt), 64'd1);
    chk("r5_lit",     64'(got_data[5]), 64'h5555_5555);
    chk("r15_lit",    64'(got_data[15]), 64'hFFFF_FFFF);
    chk("pc_lit",     64'(got_pc), 64'h0000_3000);

    // Backpressure on beat 5.
    start_dump(32'h0000_4000);
    wait_read(5'd5, "wait_r5");
    out_if.out_ready = 1'b0;
    repeat (11) tick();
    out_if.out_ready = 1'b1;
    wait_idle(300);
    chk("stall_len",  64'(hs_cyc[5] - pres_cyc[5]), 64'd10);
    chk("beat6_after_release", 64'(pres_cyc[6] - hs_cyc[5]), 64'd2);

    // Write to r7 in its own READ cycle must come through the bypass.
    start_dump(32'h0000_5000);
    wait_read(5'd7, "wait_r7");
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    wait_idle(300);
    chk("bypass_r7", 64'(got_data[7]), 64'hDEAD_BEEF);

    // Reset while beat 12 is offered.
    start_dump(32'h0000_6000);
    n = 0;
    while (!(out_if.out_valid && out_if.out_idx == 6'd12) && n < 200) begin
      tick();
      n++;
    end
    chk("wait_b12", 64'(n < 200), 64'd1);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("no_done_after_rst", 64'(done_cnt - d0), 64'd0);
    start_dump(32'h0000_7000);
    wait_idle(300);
    chk("redump_count", 64'(beat_cnt), 64'(NB));

    // Start pulses while busy must not restart the dump.
    d0 = done_cnt;
    start_dump(32'h0000_8000);
    for (int k = 0; k < 60; k++) begin
      start = (k % 3 == 0);
      pc_in = $urandom;
      tick();
    end
    start = 1'b0;
    wait_idle(300);
    repeat (5) tick();
    chk("single_done", 64'(done_cnt - d0), 64'd1);
    chk("busy_start_count", 64'(beat_cnt), 64'(NB));

    // Random backpressure, start pulses and writes to registers not yet read.
    d0 = done_cnt;
    for (int k = 0; k < 800; k++) begin
      out_if.out_ready = ($urandom_range(0, 9) < 7);
      start = ($urandom_range(0, 24) == 0);
      pc_in = $urandom;
      we = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        j = -1;
        if (!m_active) j = $urandom_range(1, 31);
        else if (exp_idx < 31) j = $urandom_range(exp_idx + 1, 31);
        if (j > 0) begin
          we = 1'b1; waddr = 5'(j); wdata = $urandom;
        end
      end
      tick();
    end
    start = 1'b0;
    we = 1'b0;
    out_if.out_ready = 1'b1;
    wait_idle(300);
    chk("rand_dumps_done", 64'(done_cnt > d0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/grf_dump.md
# grf_dump

Sequential read-out engine for the 32×32 general register file. On a start pulse it walks register indices 0..31 through one GRF read port, captures each value, and streams it out as one beat per register over a valid/ready interface, tagged with the index and the PC sampled at start. It sits beside the GRF in the datapath and is used for state dumps and end-of-test comparison. It is the reader of what the writeback stage writes.

## Interface
- `DATA_W`, default 32: register and beat data width.
- `REG_CNT`, default 32: number of registers walked; fixed at 32 for this CPU.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: begin a dump; sampled only in IDLE.
- `pc` input, 32 bits: PC value captured on the accepted start.
- `busy` output, 1 bit: high from the cycle after an accepted start until DONE.
- `done` output, 1 bit: one-cycle pulse after the final beat is accepted.
- `raddr` output, 5 bits: address to the GRF read port (the A1/A2-style input).
- `rdata` input, 32 bits: GRF read data, combinational from `raddr`. Includes the GRF write-bypass.
- `out_valid` output, 1 bit: a beat is presented.
- `out_ready` input, 1 bit: the consumer accepts the beat.
- `out_idx` output, 6 bits: register index of the beat (0..31), or 32 for the checksum beat.
- `out_data` output, 32 bits: beat payload.
- `out_pc` output, 32 bits: PC captured at start; constant for the whole dump.
- `out_last` output, 1 bit: high on the final beat.

## Operation
- States are IDLE, READ, SEND, SUM, DONE.
- IDLE:
  - `busy=0`.
  - On `start=1`: capture `pc` into `out_pc`, set idx=0, clear the checksum accumulator, go to READ.
- READ:
  - `raddr=idx`.
  - Latch `rdata` into `out_data` and set `out_idx=idx`, then go to SEND.
  - XOR `rdata` into the accumulator.
- SEND:
  - `out_valid=1`; `out_data`, `out_idx` and `out_last` are held stable until the handshake.
  - On `out_valid && out_ready`: if idx==31, go to SUM when the checksum is enabled, otherwise to DONE. Else increment idx and go to READ.
- SUM:
  - Present `out_data` = accumulator, `out_idx=32`, `out_last=1`, `out_valid=1`.
  - On handshake go to DONE.
- DONE:
  - `done=1` for exactly one cycle, `busy=0`, return to IDLE.
- `start` is ignored outside IDLE, including in the DONE cycle.
- Register values are sampled at their READ cycle, not as a snapshot at start. A GRF write landing in the same cycle is seen through the GRF bypass.
- `raddr` is 0 outside READ.
- idx is 5 bits and never wraps; the 31→next transition is handled explicitly by the state machine.

## Timing
- Reset value of every output is 0: `busy`, `done`, `raddr`, `out_valid`, `out_idx`, `out_data`, `out_pc`, `out_last`.
- Internal state after reset: state=IDLE, idx=0, accumulator=0.
- `reset` during any state returns to IDLE on the next edge:
  - `out_valid` drops and no `done` pulse is produced.
  - A beat presented in that cycle is dropped even if `out_ready=1`.
- Start to first `out_valid`: 2 cycles (IDLE→READ→SEND).
- With `out_ready` held high, each beat takes 2 cycles (READ+SEND).
  - 32 beats take 64 cycles.
  - The checksum beat adds 1 cycle.
  - `done` follows the last handshake by 1 cycle.
- Backpressure: `out_ready=0` holds the SEND or SUM state indefinitely with the payload stable.
- `out_valid` never drops without a handshake, except on reset.

## Configuration
- `GRF_DUMP_CHECKSUM_EN` defined:
  - After register 31 the block emits a 33rd beat: `out_idx=32`, data = XOR of the 32 emitted words.
  - `out_last` is high only on that beat.
- `GRF_DUMP_CHECKSUM_EN` undefined:
  - SUM state and accumulator are absent.
  - `out_last=1` on the register 31 beat.
  - A dump is exactly 32 beats.

## Structure
- Shared package holds:
  - the state enum (IDLE, READ, SEND, SUM, DONE);
  - `REG_CNT`=32 and `LAST_IDX`=31;
  - `CHK_IDX`=6'd32.
- No sub-module; a single FSM plus idx counter and accumulator.
- The GRF is instantiated by the parent, not inside this block.

## Test plan
- Preload GRF with r[i]=i*0x11111111 (r0=0), pulse start with `pc=0x00003000`, `out_ready=1`:
  - 32 beats with `out_idx` 0..31 and matching data, all carrying `out_pc=0x00003000`;
  - first `out_valid` 2 cycles after start; `done` at cycle 65 without checksum.
- Same stimulus with `GRF_DUMP_CHECKSUM_EN`: 33rd beat with `out_idx=32` carries the XOR of the 32 words, and `out_last` is high only on that beat.
- Hold `out_ready=0` for 10 cycles at beat 5: `out_valid` stays high and `out_data=r5` is stable; on release, beat 6 follows 2 cycles later.
- Write r7=0xDEADBEEF in the same cycle `raddr=7`: beat 7 carries 0xDEADBEEF through the bypass.
- Assert `reset` while in SEND at beat 12: next cycle all outputs are 0 and no `done`; a fresh start then dumps from idx 0.
- Pulse `start` repeatedly while busy: no restart, the dump completes normally with a single `done` pulse.
